// File: rtl/stage3_lsu_split_unit.sv
// stage3_lsu_split_unit
// Load/store access unit between the stage3 memory stage and the generic data
// bus. One request at a time. Accesses that straddle an XLEN-aligned boundary
// are issued as two aligned beats. Load bytes are merged and sign/zero-extended.
// Store data and byte enables are shifted into their lanes.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, a request whose
// address is not a multiple of its size issues no bus beat and completes with
// resp_misaligned=1. When undefined, such requests are split and
// resp_misaligned is tied low.
//
// Handshake: the requester raises req_valid with ren or wen and holds every
// req_* field stable until done pulses. It drops or replaces the request in the
// cycle after done. kill abandons the request at the next beat boundary, with no
// done pulse. On the bus side, a beat is presented while bus_ren or bus_wen is
// high and completes on the first clock edge that sees bus_busy=0. bus_rdata
// and bus_error are sampled on that edge.
module stage3_lsu_split_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              kill,
    output logic              done,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_error,
    output logic              resp_misaligned,
    output logic              busy,
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_byte_en,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_busy,
    input  logic              bus_error,
    output logic [1:0]        dbg_state
);

    localparam int B     = XLEN / 8;
    localparam int OFF_W = $clog2(B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [OFF_W-1:0]    off_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic                wen_q;
    logic                split_q;
    logic                err_q;
    logic [2*B-1:0]      mask2_q;
    logic [2*XLEN-1:0]   wdata2_q;
    logic [XLEN-1:0]     lo_q;
    logic [XLEN-1:0]     hi_q;

    // Next values for the capture registers, decoded from the live request.
    logic [1:0]          size_d;
    logic [OFF_W-1:0]    off_d;
    logic [3:0]          nbytes_d;
    logic                split_d;
    logic [2*B-1:0]      mask2_d;
    logic [2*XLEN-1:0]   wdata2_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                accept;
    logic                trap_flag;

    // Request decode: offset, byte count, split detection and lane-shifted data.
    always_comb begin
        size_d = req_size;
        // A dword request on a 32-bit bus has no meaning, so it is handled as a word.
        if (XLEN == 32 && req_size == 2'd3) begin
            size_d = 2'd2;
        end
        off_d    = req_addr[OFF_W-1:0];
        nbytes_d = 4'd1 << size_d;
        split_d  = (5'(off_d) + 5'(nbytes_d)) > 5'(B);
        mask2_d  = (((2*B)'(1) << nbytes_d) - (2*B)'(1)) << off_d;
        wdata2_d = {{XLEN{1'b0}}, req_wdata} << {off_d, 3'b000};
        addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        accept   = req_valid && (req_ren || req_wen) && !kill;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal_d;
    logic mis_q;

    // Natural-alignment test: the offset must be a multiple of the access size.
    always_comb begin
        misal_d = (off_d & OFF_W'(nbytes_d - 4'd1)) != '0;
    end

    // Trap flag is captured at acceptance and held until the response.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            mis_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            mis_q <= misal_d;
        end
    end

    assign trap_flag = mis_q;
`else
    assign trap_flag = 1'b0;
`endif

    // Main FSM: capture the request, run one or two bus beats, then respond.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wen_q      <= 1'b0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
            mask2_q    <= '0;
            wdata2_q   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= addr_d;
                        off_q      <= off_d;
                        size_q     <= size_d;
                        unsigned_q <= req_unsigned;
                        wen_q      <= req_wen;
                        split_q    <= split_d;
                        err_q      <= 1'b0;
                        mask2_q    <= mask2_d;
                        wdata2_q   <= wdata2_d;
`ifdef LSU_MISALIGN_TRAP_EN
                        state_q    <= misal_d ? RESP : BEAT0;
`else
                        state_q    <= BEAT0;
`endif
                    end
                end
                BEAT0: begin
                    if (!bus_busy) begin
                        lo_q <= bus_rdata;
                        if (bus_error) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (kill) begin
                            state_q <= IDLE;
                        end else if (split_q) begin
                            state_q <= BEAT1;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                BEAT1: begin
                    if (!bus_busy) begin
                        hi_q <= bus_rdata;
                        if (bus_error) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (kill) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   keep;
    logic [XLEN-1:0]   sign_sel;
    logic [6:0]        nbits;
    logic              sign;
    logic [XLEN-1:0]   ext;

    // Load merge: realign the two beats and extend the 8n-bit field to XLEN.
    always_comb begin
        merged   = {hi_q, lo_q} >> {off_q, 3'b000};
        low      = merged[XLEN-1:0];
        nbits    = 7'd8 << size_q;
        // A shift by XLEN yields zero, so a full-width access keeps every bit.
        keep     = (XLEN'(1) << nbits) - XLEN'(1);
        sign_sel = XLEN'(1) << (nbits - 7'd1);
        sign     = |(low & sign_sel) && !unsigned_q;
        ext      = (low & keep) | (sign ? ~keep : '0);
    end

    // Output decode from the registered state and captured request.
    always_comb begin
        bus_ren         = 1'b0;
        bus_wen         = 1'b0;
        bus_addr        = '0;
        bus_byte_en     = '0;
        bus_wdata       = '0;
        done            = (state_q == RESP);
        busy            = (state_q != IDLE);
        resp_error      = done && err_q;
        resp_misaligned = done && trap_flag;
        resp_rdata      = '0;
        dbg_state       = state_q;
        if (done && !wen_q && !err_q && !trap_flag) begin
            resp_rdata = ext;
        end
        case (state_q)
            BEAT0: begin
                bus_ren     = !wen_q;
                bus_wen     = wen_q;
                bus_addr    = addr_q;
                bus_byte_en = mask2_q[B-1:0];
                bus_wdata   = wdata2_q[XLEN-1:0];
            end
            BEAT1: begin
                bus_ren     = !wen_q;
                bus_wen     = wen_q;
                bus_addr    = addr_q + ADDR_W'(B);
                bus_byte_en = mask2_q[2*B-1:B];
                bus_wdata   = wdata2_q[2*XLEN-1:XLEN];
            end
            default: begin
            end
        endcase
    end

endmodule
